// File: rtl/led_seq_ctrl.sv
// Round-robin scheduler for a shared LED bank: grants one requester a fixed
// slot of prescaled step ticks and rotates its captured pattern left each tick.
module led_seq_ctrl #(
    parameter int WIDTH      = 12,
    parameter int NREQ       = 3,
    parameter int PRESCALE   = 4,
    parameter int SLOT_STEPS = 12,
    localparam int CW        = (SLOT_STEPS > 1) ? $clog2(SLOT_STEPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  pat_in,
    output logic [WIDTH-1:0]       leds,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   step,
    output logic [CW-1:0]          step_cnt
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             step_q, step_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic [WIDTH-1:0] win_pat;
    logic             tick;
    logic             last_step;
    logic             owner_req;
    logic             load;

    // Round-robin search starting one past the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_pat = pat_in[int'(win_idx)*WIDTH +: WIDTH];
    end

    assign tick      = (pre_q == PW'(PRESCALE - 1));
    assign last_step = (cnt_q == CW'(SLOT_STEPS - 1));
    assign owner_req = req[ptr_q];

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        grant_d = grant_q;
        step_d  = 1'b0;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        ptr_d   = ptr_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                leds_d  = '0;
                grant_d = '0;
                cnt_d   = '0;
                pre_d   = '0;
                load    = win_found;
            end
            RUN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    step_d = 1'b1;
                    if (!last_step && owner_req) begin
                        leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                        cnt_d  = cnt_q + 1'b1;
                    end else if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        leds_d  = '0;
                        grant_d = '0;
                        cnt_d   = '0;
                        pre_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new grant, from IDLE or back-to-back at slot end, restarts the slot.
        if (load) begin
            state_d = RUN;
            grant_d = NREQ'(1) << win_idx;
            leds_d  = win_pat;
            cnt_d   = '0;
            pre_d   = '0;
            ptr_d   = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            leds_q  <= '0;
            grant_q <= '0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
            pre_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            grant_q <= grant_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
        end
    end

    assign leds     = leds_q;
    assign grant    = grant_q;
    assign busy     = (state_q == RUN);
    assign step     = step_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: slot-level reference model checked every cycle,
// plus directed literal checks on rotation, handover, early end and reset.
module tb_led_seq_ctrl;

    localparam int WIDTH = 12;
    localparam int NREQ  = 3;
    localparam int PRE   = 4;
    localparam int SLOT  = 12;
    localparam int CW    = $clog2(SLOT);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] pat_in = '0;
    logic [WIDTH-1:0]      leds;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  step;
    logic [CW-1:0]         step_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    led_seq_ctrl #(
        .WIDTH(WIDTH),
        .NREQ(NREQ),
        .PRESCALE(PRE),
        .SLOT_STEPS(SLOT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .pat_in(pat_in),
        .leds(leds),
        .grant(grant),
        .busy(busy),
        .step(step),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Model: a slot is described by its owner, captured pattern, clocks since
    // grant and number of rotations done; outputs follow from those.
    bit               m_run   = 0;
    int               m_owner = 0;
    int               m_ptr   = NREQ - 1;
    logic [WIDTH-1:0] m_base  = '0;
    int               m_k     = 0;
    int               m_cyc   = 0;
    bit               m_step  = 0;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
        int s;
        s = n % WIDTH;
        return (v << s) | (v >> (WIDTH - s));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run  = 0;
                m_ptr  = NREQ - 1;
                m_step = 0;
                m_k    = 0;
                m_cyc  = 0;
            end else begin
                bit do_grant;
                do_grant = 0;
                m_step   = 0;
                if (m_run) begin
                    m_cyc = m_cyc + 1;
                    if (m_cyc % PRE == 0) begin
                        m_step = 1;
                        if ((m_cyc / PRE) < SLOT && req[m_owner]) m_k = m_k + 1;
                        else if (req != 0) do_grant = 1;
                        else m_run = 0;
                    end
                end else if (req != 0) begin
                    do_grant = 1;
                end
                if (do_grant) begin
                    for (int i = 1; i <= NREQ; i++) begin
                        if (do_grant && req[(m_ptr + i) % NREQ]) begin
                            m_owner  = (m_ptr + i) % NREQ;
                            do_grant = 0;
                        end
                    end
                    m_ptr  = m_owner;
                    m_base = pat_in[m_owner*WIDTH +: WIDTH];
                    m_k    = 0;
                    m_cyc  = 0;
                    m_run  = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("m_leds",  32'(leds),     m_run ? 32'(rotl(m_base, m_k)) : 32'd0);
            chk("m_grant", 32'(grant),    m_run ? (32'd1 << m_owner) : 32'd0);
            chk("m_busy",  32'(busy),     32'(m_run));
            chk("m_step",  32'(step),     32'(m_step));
            chk("m_cnt",   32'(step_cnt), m_run ? 32'(m_k) : 32'd0);
        end
    end

    task automatic set_pat(input int i, input logic [WIDTH-1:0] v);
        pat_in[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, then release idle
        rst_n  = 1'b0;
        req    = NREQ'($urandom);
        pat_in = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("rst_leds",  32'(leds),  32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_step",  32'(step),  32'd0);
        req   = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_leds", 32'(leds), 32'd0);

        // Two requesters alternate with no gap
        do_reset();
        set_pat(0, 12'h0ED);
        set_pat(2, 12'hF00);
        req = 3'b101;
        @(negedge clk);
        chk("rr_first", 32'(grant), 32'h1);
        repeat (47) @(negedge clk);
        chk("rr_hold0", 32'(grant), 32'h1);
        @(negedge clk);
        chk("rr_hand2", 32'(grant), 32'h4);
        chk("rr_led2",  32'(leds),  32'hF00);
        repeat (47) @(negedge clk);
        chk("rr_hold2", 32'(grant), 32'h4);
        @(negedge clk);
        chk("rr_back0", 32'(grant), 32'h1);
        chk("rr_led0",  32'(leds),  32'h0ED);

        // Single requester rotation, slot reload, mid-slot pattern change
        do_reset();
        set_pat(0, 12'h0ED);
        req = 3'b001;
        @(negedge clk);
        chk("s_grant", 32'(grant), 32'h1);
        chk("s_led0",  32'(leds),  32'h0ED);
        repeat (4) @(negedge clk);
        chk("s_led1",  32'(leds),  32'h1DA);
        chk("s_step",  32'(step),  32'h1);
        chk("s_cnt1",  32'(step_cnt), 32'h1);
        repeat (4) @(negedge clk);
        chk("s_led2",  32'(leds),  32'h3B4);
        repeat (36) @(negedge clk);
        chk("s_led11", 32'(leds),  32'h876);
        chk("s_cnt11", 32'(step_cnt), 32'd11);
        repeat (4) @(negedge clk);
        chk("s_reload", 32'(leds), 32'h0ED);
        chk("s_cnt0",   32'(step_cnt), 32'h0);
        chk("s_regr",   32'(grant), 32'h1);
        repeat (2) @(negedge clk);
        set_pat(0, 12'hFFF);
        repeat (2) @(negedge clk);
        chk("p_keep",  32'(leds), 32'h1DA);
        repeat (43) @(negedge clk);
        chk("p_last",  32'(leds), 32'h876);
        @(negedge clk);
        chk("p_new",   32'(leds), 32'hFFF);

        // Owner drops request mid-slot: early end at the next tick
        do_reset();
        set_pat(1, 12'hA5C);
        req = 3'b010;
        @(negedge clk);
        chk("e_grant", 32'(grant), 32'h2);
        repeat (8) @(negedge clk);
        chk("e_led2",  32'(leds), 32'h972);
        req = 3'b000;
        repeat (3) @(negedge clk);
        chk("e_hold",  32'(leds), 32'h972);
        chk("e_busy1", 32'(busy), 32'h1);
        @(negedge clk);
        chk("e_busy0", 32'(busy),  32'h0);
        chk("e_grnt0", 32'(grant), 32'h0);
        chk("e_leds0", 32'(leds),  32'h0);

        // Asynchronous reset mid-slot, pointer restored
        do_reset();
        set_pat(0, 12'h0ED);
        req = 3'b001;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_leds",  32'(leds),  32'h0);
        chk("a_grant", 32'(grant), 32'h0);
        chk("a_busy",  32'(busy),  32'h0);
        chk("a_cnt",   32'(step_cnt), 32'h0);
        req = 3'b110;
        set_pat(1, 12'h123);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("a_rr",    32'(grant), 32'h2);
        chk("a_pat",   32'(leds),  32'h123);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
